// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one external 4-bit ALU between two
// requesters. An accepted operation is held on the ALU for SETTLE_CYCLES
// cycles, the results are registered and presented on a valid/ready response
// port with the id of the requester that issued the operation.
// Optional feature: define ALU_ARB_OPCODE_CHECK_EN to reject opcodes above
// 4'b1011 with an immediate error response instead of executing them.
// dbg_state exposes the FSM state (0 IDLE, 1 EXEC, 2 RESP).
//
// Handshake rule for both sides: a transfer happens on a rising clk edge where
// valid and ready are both high; valid never waits for ready, and the sender
// holds its payload stable until the transfer edge.
module alu_arbiter #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req0_opcode,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic [0:0] req0_cin,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [3:0] req1_opcode,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    input  logic [0:0] req1_cin,
    output logic [3:0] alu_opcode,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic       alu_cin,
    input  logic [3:0] alu_out,
    input  logic [3:0] alu_out_2,
    input  logic       alu_cout,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [3:0] rsp_out,
    output logic [3:0] rsp_out_2,
    output logic       rsp_cout,
    output logic       rsp_err,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Counter value on the last settle cycle of EXEC.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] op_q, op_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic       cin_q, cin_d;
    logic       id_q, id_d;
    logic       last_q, last_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] rsp_out_q, rsp_out_d;
    logic [3:0] rsp_out_2_q, rsp_out_2_d;
    logic       rsp_cout_q, rsp_cout_d;
`ifdef ALU_ARB_OPCODE_CHECK_EN
    logic       rsp_err_q, rsp_err_d;
`endif

    logic       grant0, grant1;
    logic [3:0] sel_op, sel_a, sel_b;
    logic       sel_cin;

    // Round-robin grant, only offered in IDLE and never while reset is high.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == IDLE && !rst) begin
            if (req0_valid && (!req1_valid || last_q)) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Payload of whichever requester holds the grant.
    always_comb begin
        sel_op  = grant1 ? req1_opcode : req0_opcode;
        sel_a   = grant1 ? req1_a      : req0_a;
        sel_b   = grant1 ? req1_b      : req0_b;
        sel_cin = grant1 ? req1_cin[0] : req0_cin[0];
    end

    // Next-state and datapath updates for the IDLE -> EXEC -> RESP cycle.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        cin_d       = cin_q;
        id_d        = id_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        rsp_out_d   = rsp_out_q;
        rsp_out_2_d = rsp_out_2_q;
        rsp_cout_d  = rsp_cout_q;
`ifdef ALU_ARB_OPCODE_CHECK_EN
        rsp_err_d   = rsp_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    op_d    = sel_op;
                    a_d     = sel_a;
                    b_d     = sel_b;
                    cin_d   = sel_cin;
                    id_d    = grant1;
                    last_d  = grant1;
                    cnt_d   = 4'd0;
                    state_d = EXEC;
`ifdef ALU_ARB_OPCODE_CHECK_EN
                    // Illegal opcodes never reach the ALU result path.
                    if (sel_op > 4'b1011) begin
                        rsp_out_d   = 4'd0;
                        rsp_out_2_d = 4'd0;
                        rsp_cout_d  = 1'b0;
                        rsp_err_d   = 1'b1;
                        state_d     = RESP;
                    end
`endif
                end
            end
            EXEC: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == SETTLE_LAST) begin
                    rsp_out_d   = alu_out;
                    rsp_out_2_d = alu_out_2;
                    rsp_cout_d  = alu_cout;
`ifdef ALU_ARB_OPCODE_CHECK_EN
                    rsp_err_d   = 1'b0;
`endif
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; last grant resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= 4'd0;
            a_q         <= 4'd0;
            b_q         <= 4'd0;
            cin_q       <= 1'b0;
            id_q        <= 1'b0;
            last_q      <= 1'b1;
            cnt_q       <= 4'd0;
            rsp_out_q   <= 4'd0;
            rsp_out_2_q <= 4'd0;
            rsp_cout_q  <= 1'b0;
`ifdef ALU_ARB_OPCODE_CHECK_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cin_q       <= cin_d;
            id_q        <= id_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            rsp_out_q   <= rsp_out_d;
            rsp_out_2_q <= rsp_out_2_d;
            rsp_cout_q  <= rsp_cout_d;
`ifdef ALU_ARB_OPCODE_CHECK_EN
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    assign alu_opcode = op_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_cin    = cin_q;
    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = id_q;
    assign rsp_out    = rsp_out_q;
    assign rsp_out_2  = rsp_out_2_q;
    assign rsp_cout   = rsp_cout_q;
`ifdef ALU_ARB_OPCODE_CHECK_EN
    assign rsp_err    = rsp_err_q;
`else
    assign rsp_err    = 1'b0;
`endif
    assign dbg_state  = state_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, meaning cycles operands are held on the ALU before results are sampled (legal 1..15).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have ports req0_valid / req1_valid, input, 1, requester N has an operation pending.
REQ-005 SHALL have ports req0_ready / req1_ready, output, 1, requester N's operation is accepted this cycle.
REQ-006 SHALL have ports reqN_opcode [3:0], reqN_a [3:0], reqN_b [3:0], reqN_cin [0:0], input, per requester: ALU opcode, operands and carry-in.
REQ-007 SHALL have ports alu_opcode, alu_a, alu_b (4 each) and alu_cin (1), output, driving the shared ALU.
REQ-008 SHALL have ports alu_out, alu_out_2 (4 each) and alu_cout (1), input, results returned by the shared ALU.
REQ-009 SHALL have ports rsp_valid (output, 1) and rsp_ready (input, 1), the response handshake.
REQ-010 SHALL have ports rsp_id (1), rsp_out (4), rsp_out_2 (4), rsp_cout (1), rsp_err (1), all outputs: granted requester, registered results, error flag.

Function
REQ-011 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE, one-hot or binary encoding.
REQ-012 In IDLE, SHALL assert exactly one reqN_ready, combinationally, when at least one reqN_valid is high; a transfer occurs when that requester's valid and ready are both high.
REQ-013 Arbitration SHALL be round-robin: on simultaneous valids, grant the requester not granted last; a lone valid is always granted.
REQ-014 On transfer, SHALL register opcode, a, b, cin and the grant id, update the last-grant pointer, clear the settle counter, and enter EXEC.
REQ-015 alu_opcode/alu_a/alu_b/alu_cin SHALL be driven from the registered operands at all times, stable across EXEC and RESP.
REQ-016 In EXEC, the settle counter SHALL increment each cycle; on the cycle it equals SETTLE_CYCLES-1, SHALL register alu_out, alu_out_2 and alu_cout into rsp_* and enter RESP.
REQ-017 Response latency SHALL be exactly SETTLE_CYCLES cycles from the accepting edge to rsp_valid high; throughput is one operation per SETTLE_CYCLES+2 cycles.
REQ-018 In RESP, rsp_valid SHALL be high and rsp_* held stable until rsp_ready is sampled high; then enter IDLE.
REQ-019 reqN_ready SHALL be low in EXEC and RESP regardless of valids; requests wait without loss.
REQ-020 Back-pressure (rsp_ready low) SHALL stall indefinitely in RESP without overwriting the response.
REQ-021 rsp_id SHALL equal the index of the requester whose operation produced the response.

Reset
REQ-022 While rst is high, SHALL force state IDLE, all reqN_ready and rsp_valid low, all rsp_* zero, ALU drive registers zero, settle counter zero.
REQ-023 Reset SHALL set the last-grant pointer to requester 1, so requester 0 wins the first tie.
REQ-024 Reset asserted mid-EXEC or mid-RESP SHALL discard the operation; no response is ever produced for it.

Configuration
REQ-025 Macro ALU_ARB_OPCODE_CHECK_EN defined: an accepted opcode above 4'b1011 SHALL skip EXEC, enter RESP on the next edge with rsp_err=1 and rsp_out/rsp_out_2/rsp_cout zero; legal opcodes give rsp_err=0.
REQ-026 Macro undefined: rsp_err SHALL be constant 0 and every opcode SHALL be executed through EXEC normally.

Verification
REQ-027 req0 only: opcode 0111, a=9, b=8, cin=0, SETTLE_CYCLES=1 -> rsp_valid one cycle after accept, rsp_out=1, rsp_cout=1, rsp_id=0.
REQ-028 Both valid continuously, rsp_ready=1, after reset -> grants strictly alternate 0,1,0,1; first rsp_id=0.
REQ-029 req1 opcode 1001, a=7, b=6, rsp_ready held low 10 cycles -> rsp_out=4'h A, rsp_out_2=4'h2 stable throughout; both ready outputs low; completion on rsp_ready.
REQ-030 SETTLE_CYCLES=3, opcode 1010, a=13, b=4 -> rsp_valid exactly 3 cycles after accept, rsp_out=3, rsp_out_2=1.
REQ-031 rst pulsed during EXEC -> no rsp_valid ever for that operation; next request granted to req0 on a tie.
REQ-032 With ALU_ARB_OPCODE_CHECK_EN, opcode 1111 -> rsp_valid next cycle, rsp_err=1, outputs zero; without macro, rsp_err=0.
